// File: rtl/csi2_raw10_unpacker_if.sv
// csi2_raw10_unpacker_if: receiver image-word inputs and unpacked pixel-group outputs
interface csi2_raw10_unpacker_if #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12
);
    logic [3:0][7:0]     image_data;
    logic [5:0]          image_data_type;
    logic                image_data_enable;
    logic                frame_start;
    logic                frame_end;
    logic                line_start;
    logic                line_end;
    logic [3:0][9:0]     pixel;
    logic                pixel_enable;
    logic [X_WIDTH-1:0]  pixel_x;
    logic [Y_WIDTH-1:0]  pixel_y;
    logic                frame_done;
    logic                line_error;
    logic [2:0]          residual;
    modport master (
        output image_data, image_data_type, image_data_enable,
        output frame_start, frame_end, line_start, line_end,
        input  pixel, pixel_enable, pixel_x, pixel_y, frame_done, line_error, residual
    );
    modport slave (
        input  image_data, image_data_type, image_data_enable,
        input  frame_start, frame_end, line_start, line_end,
        output pixel, pixel_enable, pixel_x, pixel_y, frame_done, line_error, residual
    );
endinterface

// File: rtl/csi2_raw10_unpacker.sv
// csi2_raw10_unpacker: unpacks CSI-2 RAW10 (5 bytes -> 4 pixels) from 4-byte words,
// tracking x/y coordinates and reporting lines that end with leftover bytes.
module csi2_raw10_unpacker #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    csi2_raw10_unpacker_if.slave  i_bus
);
    logic [7:0]         r_buf [8];
    logic [3:0]         r_cnt;
    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    logic               r_fs_q, r_fe_q, r_ls_q, r_le_q;
    logic [3:0][9:0]    r_pixel;
    logic               r_pixel_enable;
    logic [X_WIDTH-1:0] r_pixel_x;
    logic [Y_WIDTH-1:0] r_pixel_y;
    logic               r_frame_done;
    logic               r_line_error;
    logic [2:0]         r_residual;
    logic               w_fs, w_fe, w_ls, w_le;
    logic               w_acc, w_emit, w_lerr;
    logic [3:0]         w_avail;
    logic [7:0]         w_ext  [8];
    logic [7:0]         w_next [8];
    logic [3:0][9:0]    w_pix;
    assign w_fs    = i_bus.frame_start & ~r_fs_q;
    assign w_fe    = i_bus.frame_end   & ~r_fe_q;
    assign w_ls    = i_bus.line_start  & ~r_ls_q;
    assign w_le    = i_bus.line_end    & ~r_le_q;
    assign w_acc   = i_bus.image_data_enable && i_bus.image_data_type == 6'h2B && !(w_fs || w_fe || w_ls || w_le);
    assign w_avail = r_cnt + 4'd4;
    assign w_emit  = w_acc && w_avail >= 4'd5;
    assign w_lerr  = w_le && !w_fs && !w_ls && r_cnt != 4'd0;
    // New word lands right after the bytes already buffered; the count never exceeds 4 here.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_ext[i] = r_buf[i];
            for (int j = 0; j < 4; j++)
                if (r_cnt + 4'(j) == 4'(i)) w_ext[i] = i_bus.image_data[j];
        end
        for (int i = 0; i < 8; i++)
            w_next[i] = w_emit ? ((i < 3) ? w_ext[(i + 5) % 8] : 8'h0) : w_ext[i];
        for (int k = 0; k < 4; k++)
            w_pix[k] = {w_ext[k], w_ext[4][2*k +: 2]};
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_buf          <= '{default: 8'h0};
            r_cnt          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            {r_fs_q, r_fe_q, r_ls_q, r_le_q} <= '0;
            r_pixel        <= '0;
            r_pixel_enable <= 1'b0;
            r_pixel_x      <= '0;
            r_pixel_y      <= '0;
            r_frame_done   <= 1'b0;
            r_line_error   <= 1'b0;
            r_residual     <= '0;
        end else begin
            {r_fs_q, r_fe_q, r_ls_q, r_le_q} <= {i_bus.frame_start, i_bus.frame_end, i_bus.line_start, i_bus.line_end};
            r_pixel_enable <= w_emit;
            r_frame_done   <= w_fe;
            r_line_error   <= w_lerr;
            r_residual     <= w_lerr ? r_cnt[2:0] : 3'd0;
            if (w_emit) begin
                r_pixel   <= w_pix;
                r_pixel_x <= r_x;
                r_pixel_y <= r_y;
            end
            if (w_fs) begin
                r_y   <= '0;
                r_x   <= '0;
                r_cnt <= '0;
            end else if (w_ls) begin
                r_x   <= '0;
                r_cnt <= '0;
            end else if (w_le) begin
                r_y   <= r_y + Y_WIDTH'(1);
                r_x   <= '0;
                r_cnt <= '0;
            end else if (w_acc) begin
                r_buf <= w_next;
                r_cnt <= w_emit ? w_avail - 4'd5 : w_avail;
                if (w_emit) r_x <= r_x + X_WIDTH'(4);
            end
        end
    end
    assign i_bus.pixel        = r_pixel;
    assign i_bus.pixel_enable = r_pixel_enable;
    assign i_bus.pixel_x      = r_pixel_x;
    assign i_bus.pixel_y      = r_pixel_y;
    assign i_bus.frame_done   = r_frame_done;
    assign i_bus.line_error   = r_line_error;
    assign i_bus.residual     = r_residual;
endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// tb_csi2_raw10_unpacker: random and directed stimulus checked every cycle against a
// byte-queue reference model, plus literal expectations for the directed scenarios.
module tb_csi2_raw10_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    csi2_raw10_unpacker_if bus ();
    csi2_raw10_unpacker dut (.i_clock(clk), .i_reset(rst), .i_bus(bus));
    // Reference model: a plain byte queue; every 5 queued bytes form one group.
    byte unsigned    q[$];
    int              mx = 0, my = 0;
    logic            p_fs = 0, p_fe = 0, p_ls = 0, p_le = 0;
    logic [3:0][9:0] e_pix = '0;
    logic            e_pe = 0, e_fd = 0, e_le = 0;
    logic [11:0]     e_px = '0, e_py = '0;
    logic [2:0]      e_res = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mx = 0; my = 0;
            {p_fs, p_fe, p_ls, p_le} = '0;
            e_pix = '0; e_pe = 0; e_fd = 0; e_le = 0; e_px = '0; e_py = '0; e_res = '0;
        end else begin
            logic fs_e, fe_e, ls_e, le_e;
            fs_e = bus.frame_start & !p_fs;
            fe_e = bus.frame_end & !p_fe;
            ls_e = bus.line_start & !p_ls;
            le_e = bus.line_end & !p_le;
            {p_fs, p_fe, p_ls, p_le} = {bus.frame_start, bus.frame_end, bus.line_start, bus.line_end};
            e_pe = 0; e_le = 0; e_res = 0; e_fd = fe_e;
            if (fs_e) begin
                q.delete(); mx = 0; my = 0;
            end else if (ls_e) begin
                q.delete(); mx = 0;
            end else if (le_e) begin
                if (q.size() != 0) begin
                    e_le = 1; e_res = 3'(q.size());
                end
                q.delete(); my = my + 1; mx = 0;
            end else if (bus.image_data_enable && bus.image_data_type == 6'h2B && !fe_e) begin
                for (int j = 0; j < 4; j++) q.push_back(bus.image_data[j]);
                if (q.size() >= 5) begin
                    byte unsigned b [5];
                    for (int j = 0; j < 5; j++) b[j] = q.pop_front();
                    for (int k = 0; k < 4; k++) e_pix[k] = 10'(b[k] * 4 + ((b[4] >> (2 * k)) % 4));
                    e_px = 12'(mx % 4096);
                    e_py = 12'(my % 4096);
                    mx = mx + 4;
                    e_pe = 1;
                end
            end
        end
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    always begin
        @(posedge clk);
        #2;
        check("pixel_enable", 64'(bus.pixel_enable), 64'(e_pe));
        check("pixel", 64'(bus.pixel), 64'(e_pix));
        check("pixel_x", 64'(bus.pixel_x), 64'(e_px));
        check("pixel_y", 64'(bus.pixel_y), 64'(e_py));
        check("frame_done", 64'(bus.frame_done), 64'(e_fd));
        check("line_error", 64'(bus.line_error), 64'(e_le));
        check("residual", 64'(bus.residual), 64'(e_res));
    end
    task automatic drive(input logic en, input logic [5:0] dt, input logic [31:0] d, input logic [3:0] f);
        @(negedge clk);
        bus.image_data_enable = en;
        bus.image_data_type   = dt;
        bus.image_data        = d;
        {bus.frame_start, bus.frame_end, bus.line_start, bus.line_end} = f;
    endtask
    task automatic settle();
        @(posedge clk);
        #3;
    endtask
    task automatic line(input int n);
        drive(0, 6'h2B, 0, 4'b0010);
        for (int i = 0; i < n; i++) drive(1, 6'h2B, $urandom, 4'b0000);
        drive(0, 6'h2B, 0, 4'b0001);
        drive(0, 6'h2B, 0, 4'b0000);
    endtask
    localparam logic [39:0] GRP1 = {10'h010, 10'h00C, 10'h009, 10'h005};
    initial begin
        bus.image_data_enable = 0; bus.image_data_type = 0; bus.image_data = 0;
        {bus.frame_start, bus.frame_end, bus.line_start, bus.line_end} = '0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_pe", 64'(bus.pixel_enable), 0);
        check("reset_pixel", 64'(bus.pixel), 0);
        @(negedge clk);
        rst = 0;
        // basic decode
        drive(1, 6'h2B, 32'h04030201, 0);
        settle();
        check("s1_no_group", 64'(bus.pixel_enable), 0);
        drive(1, 6'h2B, 32'h08070605, 0);
        settle();
        check("s1_pe", 64'(bus.pixel_enable), 1);
        check("s1_pixel", 64'(bus.pixel), 64'(GRP1));
        check("s1_x", 64'(bus.pixel_x), 0);
        check("s1_y", 64'(bus.pixel_y), 0);
        drive(0, 6'h2B, 0, 0);
        // 20-byte line, then 24-byte line with residual 4
        line(5);
        drive(0, 6'h2B, 0, 4'b0010);
        drive(1, 6'h2B, $urandom, 0);
        drive(1, 6'h2B, $urandom, 0);
        settle();
        check("s2_next_row_y", 64'(bus.pixel_y), 1);
        check("s2_next_row_x", 64'(bus.pixel_x), 0);
        for (int i = 0; i < 4; i++) drive(1, 6'h2B, $urandom, 0);
        drive(0, 6'h2B, 0, 4'b0001);
        settle();
        check("s3_line_error", 64'(bus.line_error), 1);
        check("s3_residual", 64'(bus.residual), 4);
        drive(0, 6'h2B, 0, 0);
        settle();
        check("s3_error_pulse", 64'(bus.line_error), 0);
        // non-RAW10 data ignored
        drive(0, 6'h2B, 0, 4'b0010);
        for (int i = 0; i < 3; i++) drive(1, 6'h2A, $urandom, 0);
        settle();
        check("s4_no_pe", 64'(bus.pixel_enable), 0);
        drive(1, 6'h2B, 32'h04030201, 0);
        drive(1, 6'h2B, 32'h08070605, 0);
        settle();
        check("s4_decode", 64'(bus.pixel), 64'(GRP1));
        check("s4_pe", 64'(bus.pixel_enable), 1);
        // frame boundaries
        drive(0, 6'h2B, 0, 4'b1000);
        drive(0, 6'h2B, 0, 0);
        for (int i = 0; i < 3; i++) line(5);
        drive(0, 6'h2B, 0, 4'b0100);
        settle();
        check("s5_frame_done", 64'(bus.frame_done), 1);
        drive(0, 6'h2B, 0, 0);
        settle();
        check("s5_frame_done_pulse", 64'(bus.frame_done), 0);
        drive(0, 6'h2B, 0, 4'b1000);
        drive(0, 6'h2B, 0, 4'b0010);
        drive(1, 6'h2B, $urandom, 0);
        drive(1, 6'h2B, $urandom, 0);
        settle();
        check("s5_y_restart", 64'(bus.pixel_y), 0);
        // asynchronous reset mid-line
        drive(0, 6'h2B, 0, 0);
        drive(1, 6'h2B, $urandom, 0);
        drive(0, 6'h2B, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        check("s6_reset_pe", 64'(bus.pixel_enable), 0);
        check("s6_reset_pixel", 64'(bus.pixel), 0);
        check("s6_reset_x", 64'(bus.pixel_x), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        drive(1, 6'h2B, 32'h04030201, 0);
        drive(1, 6'h2B, 32'h08070605, 0);
        settle();
        check("s6_pixel", 64'(bus.pixel), 64'(GRP1));
        check("s6_x", 64'(bus.pixel_x), 0);
        // accept coinciding with a line_start edge is dropped
        drive(0, 6'h2B, 0, 0);
        drive(1, 6'h2B, 32'h04030201, 4'b0010);
        settle();
        check("s7_drop_pe", 64'(bus.pixel_enable), 0);
        drive(1, 6'h2B, 32'h08070605, 0);
        settle();
        check("s7_empty_after_drop", 64'(bus.pixel_enable), 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] f;
            for (int b = 0; b < 4; b++) f[b] = ($urandom % 30) == 0;
            drive(($urandom % 4) != 0, ($urandom % 8) == 0 ? 6'h2A : 6'h2B, $urandom, f);
        end
        drive(0, 6'h2B, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
